// File: rtl/button_pkg.sv
// Shared types and helpers for the button event detector.
package button_pkg;

  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StHold,
    StLong
  } button_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/repeat pulses.
// Delay parameters are in nanoseconds; release/repeat ports carry a _pulse suffix (keywords).
module button_event
  import button_pkg::*;
#(
  parameter int unsigned LONG_DELAY   = 1_000_000_000,
  parameter int unsigned REPEAT_DELAY = 250_000_000,
  parameter int unsigned CLOCK_PERIOD = 20,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned LONG_COUNT   = LONG_DELAY / CLOCK_PERIOD;
  localparam int unsigned REPEAT_COUNT = REPEAT_DELAY / CLOCK_PERIOD;
  localparam int unsigned MAX_COUNT    = max_u(LONG_COUNT, REPEAT_COUNT);
  localparam int unsigned CNT_W        = $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_COUNT - 1);

  if (LONG_COUNT < 2) begin : g_long_chk
    $error("LONG_DELAY/CLOCK_PERIOD must be at least 2");
  end
  if (REPEAT_COUNT < 2) begin : g_repeat_chk
    $error("REPEAT_DELAY/CLOCK_PERIOD must be at least 2");
  end

  button_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      // A button already down when reset drops is ignored until it is let go.
      StArm: begin
        if (!btn_in) state_d = StIdle;
      end
      StIdle: begin
        if (btn_in) begin
          state_d = StHold;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      // Release wins over a counter reaching its terminal value on the same edge.
      StHold: begin
        if (!btn_in) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (cnt_q == LONG_TERM) begin
          state_d = StLong;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLong: begin
        if (!btn_in) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_TERM) begin
          cnt_d    = '0;
          repeat_d = REPEAT_EN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StArm;
    endcase
    held_d = (state_d == StHold) || (state_d == StLong);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StArm;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
